// File: rtl/bitty_trace_tx.sv
// bitty_trace_tx: queues {instr, d_out} records on core done strobes
// and streams each one out of a UART pin as an A5-led 5-byte frame.
module bitty_trace_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    input  logic [15:0]      instr,
    input  logic [15:0]      d_out,
    input  logic             tx_en,
    output logic             tx,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_n;
    logic [CW-1:0]    clk_cnt, clk_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [2:0]       byte_idx, byte_idx_n;
    logic [31:0]      rec, rec_n;
    logic [7:0]       cur_byte;
    logic             tx_n, busy_n;
    logic             push_req, push, pop, full, bit_end;

    assign push_req = done & tx_en;
    assign full     = (fifo_count == FULL_CNT);
    assign pop      = (state == IDLE) & (fifo_count != '0);
    // A full FIFO still takes the push when the head leaves on this edge
    assign push     = push_req & (~full | pop);
    assign bit_end  = (clk_cnt == BIT_LAST);

    // Select the frame byte being shifted out
    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = rec[31:24];
            3'd2:    cur_byte = rec[23:16];
            3'd3:    cur_byte = rec[15:8];
            3'd4:    cur_byte = rec[7:0];
            default: cur_byte = 8'hFF;
        endcase
    end

    // Next FIFO occupancy
    always_comb begin
        count_n = fifo_count;
        if (push & ~pop)
            count_n = fifo_count + 1'b1;
        else if (pop & ~push)
            count_n = fifo_count - 1'b1;
    end

    // Serialiser next-state and next registered outputs
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        rec_n      = rec;
        tx_n       = 1'b1;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                if (pop) begin
                    state_n    = START;
                    rec_n      = mem[rd_ptr];
                    byte_idx_n = '0;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    state_n   = DATA;
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    tx_n      = cur_byte[0];
                end
            end
            DATA: begin
                tx_n = cur_byte[bit_idx];
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = cur_byte[bit_idx_n];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (byte_idx == 3'd4) begin
                        state_n = IDLE;
                    end else begin
                        byte_idx_n = byte_idx + 3'd1;
                        state_n    = START;
                        tx_n       = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE) | (count_n != '0);
    end

    // Record storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push & ~reset)
            mem[wr_ptr] <= {instr, d_out};
    end

    // State, counters, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            rec        <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_cnt_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            rec        <= rec_n;
            tx         <= tx_n;
            busy       <= busy_n;
            overflow   <= overflow | (push_req & ~push);
            fifo_count <= count_n;
            wr_ptr     <= wr_ptr + PTR_W'(push);
            rd_ptr     <= rd_ptr + PTR_W'(pop);
        end
    end
endmodule

// File: tb/tb_bitty_trace_tx.sv
// tb_bitty_trace_tx: directed bench for bitty_trace_tx with a
// cycle-sampled UART receiver decoding the tx pin.
module tb_bitty_trace_tx;
    localparam int CPB = 4;

    logic        clk;
    logic        reset;
    logic        done;
    logic [15:0] instr;
    logic [15:0] d_out;
    logic        tx_en;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [3:0]  fifo_count;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    bitty_trace_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .done(done),
        .instr(instr),
        .d_out(d_out),
        .tx_en(tx_en),
        .tx(tx),
        .busy(busy),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: samples tx once per cycle, mid-bit decode
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_on = 1'b0;
    int         rx_n = 0;
    int         rx_t0 = 0;
    logic [7:0] rx_sh = 8'h00;
    int         frame_err = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_on <= 1'b0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on <= 1'b1;
                rx_n  <= 1;
                rx_t0 <= cyc;
            end
        end else begin
            rx_n <= rx_n + 1;
            if (rx_n % CPB == CPB / 2) begin
                if (rx_n / CPB >= 1 && rx_n / CPB <= 8)
                    rx_sh[rx_n / CPB - 1] <= tx;
                if (rx_n / CPB == 9) begin
                    rx_q.push_back(rx_sh);
                    rx_t.push_back(rx_t0);
                    rx_on <= 1'b0;
                    if (tx !== 1'b1)
                        frame_err <= frame_err + 1;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [39:0] frame_at(input int f);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r = r << 8;
            if (f * 5 + i < rx_q.size())
                r[7:0] = rx_q[f * 5 + i];
            else
                r[7:0] = 8'hxx;
        end
        return r;
    endfunction

    function automatic int t_at(input int idx);
        if (idx < rx_t.size())
            return rx_t[idx];
        return -1;
    endfunction

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rx_q.delete();
        rx_t.delete();
    endtask

    initial begin
        int t0;
        int peak;
        reset = 1'b1;
        done  = 1'b0;
        instr = '0;
        d_out = '0;
        tx_en = 1'b1;
        do_reset();

        // Reset state
        check("rst_tx", {63'd0, tx}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_cnt", {60'd0, fifo_count}, 64'd0);

        // Single record
        done  = 1'b1;
        instr = 16'h1234;
        d_out = 16'hABCD;
        tick(1);
        done = 1'b0;
        check("t1_cnt_e0", {60'd0, fifo_count}, 64'd1);
        check("t1_busy_e0", {63'd0, busy}, 64'd1);
        check("t1_tx_e0", {63'd0, tx}, 64'd1);
        tick(1);
        t0 = cyc;
        check("t1_tx_e1", {63'd0, tx}, 64'd0);
        check("t1_cnt_e1", {60'd0, fifo_count}, 64'd0);
        wait_idle("t1_idle", 400);
        check("t1_busy_len", 64'(cyc - t0), 64'd200);
        check("t1_nbytes", 64'(rx_q.size()), 64'd5);
        check("t1_frame", {24'd0, frame_at(0)}, {24'd0, 40'hA5_1234_ABCD});
        check("t1_start_t", 64'(t_at(0) - t0), 64'd0);
        check("t1_ovf", {63'd0, overflow}, 64'd0);

        // Burst of 10: last one dropped
        rx_q.delete();
        rx_t.delete();
        peak = 0;
        done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            instr = 16'h0100 + 16'(k);
            d_out = 16'(k);
            tick(1);
            if (int'(fifo_count) > peak)
                peak = int'(fifo_count);
        end
        done = 1'b0;
        check("t2_peak", 64'(peak), 64'd8);
        check("t2_ovf", {63'd0, overflow}, 64'd1);
        wait_idle("t2_idle", 2200);
        check("t2_nbytes", 64'(rx_q.size()), 64'd45);
        for (int f = 0; f < 9; f++) begin
            check($sformatf("t2_frame%0d", f), {24'd0, frame_at(f)},
                  {24'd0, 8'hA5, 16'h0100 + 16'(f), 16'(f)});
            if (f > 0)
                check($sformatf("t2_gap%0d", f),
                      64'(t_at(f * 5) - t_at((f - 1) * 5)), 64'd201);
        end
        check("t2_ferr", 64'(frame_err), 64'd0);
        check("t2_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Capture disabled
        do_reset();
        tx_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            done  = 1'b1;
            instr = 16'h7000 + 16'(k);
            tick(1);
            done = 1'b0;
            tick(1);
            check($sformatf("t3_quiet%0d", k),
                  {58'd0, fifo_count, tx, busy}, {58'd0, 4'd0, 1'b1, 1'b0});
        end

        // Two queued, then capture disabled: both drain
        tx_en = 1'b1;
        done  = 1'b1;
        instr = 16'h5A5A;
        d_out = 16'h0F0F;
        tick(1);
        instr = 16'hC3C3;
        d_out = 16'h3C3C;
        tick(1);
        done  = 1'b0;
        tx_en = 1'b0;
        wait_idle("t4_idle", 600);
        check("t4_f0", {24'd0, frame_at(0)}, {24'd0, 40'hA5_5A5A_0F0F});
        check("t4_f1", {24'd0, frame_at(1)}, {24'd0, 40'hA5_C3C3_3C3C});
        check("t4_gap", 64'(t_at(5) - t_at(0)), 64'd201);
        tx_en = 1'b1;

        // Reset mid-frame with two records still queued
        rx_q.delete();
        rx_t.delete();
        done  = 1'b1;
        instr = 16'h1111;
        d_out = 16'h2222;
        tick(1);
        instr = 16'h3333;
        d_out = 16'h4444;
        tick(1);
        t0    = cyc;
        instr = 16'h5555;
        d_out = 16'h6666;
        tick(1);
        done = 1'b0;
        while (cyc < t0 + 57)
            tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_rst", {57'd0, tx, busy, overflow, fifo_count},
              {57'd0, 1'b1, 1'b0, 1'b0, 4'd0});
        tick(100);
        check("t5_nbytes", 64'(rx_q.size()), 64'd1);
        check("t5_byte0", {56'd0, frame_at(0)[39:32]}, 64'hA5);
        rx_q.delete();
        rx_t.delete();
        done  = 1'b1;
        instr = 16'hBEEF;
        d_out = 16'h1357;
        tick(1);
        done = 1'b0;
        wait_idle("t5_idle", 400);
        check("t5_clean", {24'd0, frame_at(0)}, {24'd0, 40'hA5_BEEF_1357});
        check("t5_nb2", 64'(rx_q.size()), 64'd5);

        // Push on the IDLE pop edge with the FIFO full
        do_reset();
        done  = 1'b1;
        instr = 16'hA000;
        d_out = 16'h0000;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            instr = 16'hB000 + 16'(k);
            d_out = 16'hD000 + 16'(k);
            tick(1);
            if (k == 0)
                t0 = cyc;
        end
        done = 1'b0;
        check("t6_full", {60'd0, fifo_count}, 64'd8);
        while (cyc < t0 + 200)
            tick(1);
        check("t6_gap_state", {58'd0, fifo_count, tx, busy},
              {58'd0, 4'd8, 1'b1, 1'b1});
        done  = 1'b1;
        instr = 16'hCAFE;
        d_out = 16'hF00D;
        tick(1);
        done = 1'b0;
        check("t6_cnt", {60'd0, fifo_count}, 64'd8);
        check("t6_ovf", {63'd0, overflow}, 64'd0);
        check("t6_tx", {63'd0, tx}, 64'd0);
        wait_idle("t6_idle", 2500);
        check("t6_nbytes", 64'(rx_q.size()), 64'd50);
        check("t6_f1", {24'd0, frame_at(1)}, {24'd0, 40'hA5_B000_D000});
        check("t6_last", {24'd0, frame_at(9)}, {24'd0, 40'hA5_CAFE_F00D});
        check("t6_ferr", 64'(frame_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bitty_trace_tx.md
Name: bitty_trace_tx

Overview:
- Downstream trace stage for the bitty core subsystem.
- Each time the core completes an instruction (done pulse) while logging is enabled, it captures the executed instruction word and the ALU result into a small FIFO.
- Queued records are serialised out of a single UART TX pin as 5-byte frames for off-chip debug and regression logging.
- Sits beside the processor top level and consumes its done, instr and d_out outputs.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (115200 baud at 100 MHz); minimum 2.
- FIFO_DEPTH, 8, record entries; must be a power of 2.
- CNT_W, 4, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- done  input  1  core instruction-complete strobe; sampled every cycle
- instr  input  16  instruction word of the completing instruction
- d_out  input  16  core result of the completing instruction
- tx_en  input  1  capture enable; 0 = ignore done
- tx  output  1  UART serial out, idle high
- busy  output  1  1 while any record is queued or a frame is in flight
- overflow  output  1  sticky: a record was dropped because the FIFO was full
- fifo_count  output  CNT_W  records currently queued, 0..FIFO_DEPTH

Behaviour:
- Reset applies at a clk edge with reset=1:
  - tx=1, busy=0, overflow=0, fifo_count=0; FIFO pointers are cleared.
  - FSM goes to IDLE; bit and byte counters are cleared.
  - Reset aborts any frame mid-bit; tx is 1 after that edge.
- Capture:
  - At an edge with done=1 and tx_en=1, push record {instr, d_out}.
  - done held high for N cycles pushes N records.
  - tx_en=0 blocks only capture; queued records and any in-flight frame still drain.
- FIFO:
  - Push and pop in the same edge are both accepted; fifo_count is unchanged.
  - Push when fifo_count==FIFO_DEPTH with no same-edge pop: the record is dropped, overflow is set to 1 and stays set until reset.
  - Push when full with a same-edge pop is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame format, per record, bytes in this order:
  - 0xA5 (sync)
  - instr[15:8], instr[7:0]
  - d_out[15:8], d_out[7:0]
- Byte format:
  - 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - No gap between bytes within a frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count!=0, pop the head into the record register, set byte_idx=0, and go to START. tx=0 from that same edge.
  - START: after CLKS_PER_BIT cycles, go to DATA with bit_idx=0.
  - DATA: drive the current byte bit [bit_idx]. After CLKS_PER_BIT cycles, increment bit_idx; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx==4, go to IDLE; otherwise increment byte_idx and go to START.
  - After a frame ends, IDLE pops the next record on the following edge. The inter-frame gap is therefore exactly 1 idle cycle.
- Latency:
  - The capture edge E0 writes the FIFO.
  - If idle and empty, the pop occurs at edge E1 and tx goes low after E1.
  - One frame occupies 50*CLKS_PER_BIT cycles.
- Outputs:
  - busy = (state!=IDLE) | (fifo_count!=0), registered consistently with state.
  - tx is registered; no combinational glitch paths.
- Record contents are frozen at pop time; later input changes do not affect an in-flight frame.

Test Plan:
- CLKS_PER_BIT=4. One done pulse with instr=0x1234, d_out=0xABCD -> tx decodes bytes A5 12 34 AB CD. The start bit begins 1 edge after capture. busy drops 200 cycles after the start bit begins. overflow=0.
- CLKS_PER_BIT=4, FIFO_DEPTH=8. done held high for 10 consecutive cycles with instr=0x0100+k, d_out=k (k=0..9) -> fifo_count peaks at 8. Record 9 is dropped and overflow=1. Exactly 9 frames (k=0..8) are transmitted in order, each separated by 1 idle cycle.
- tx_en=0 with 3 done pulses -> fifo_count stays 0, tx stays 1, busy=0.
- Enqueue 2 records, then drop tx_en to 0 -> both frames still transmit completely.
- Assert reset during DATA bit 3 of the second byte, with 2 further records queued -> after that edge tx=1, busy=0, fifo_count=0, overflow=0. No further bytes are emitted. A new done pulse afterwards produces a clean A5-led frame.
- Push on the same edge as the IDLE pop with the FIFO full -> the record is accepted, fifo_count stays 8, overflow stays 0.
